squash_game_ctrl: RTL and testbench

Game-flow controller for the solo squash display datapath. Sequences each round through attract, serve, play, pause, miss and game-over phases by driving the datapath's `pause_n` and `new_game_n` inputs. Also keeps a 3-digit BCD score of paddle hits and a lives count. Sits between the board buttons and the squash datapath, and is clocked from the same 25 MHz pixel clock.

---
 rtl/squash_pkg.sv | 30 +++
 rtl/squash_bcd_counter.sv | 38 +++
 rtl/squash_game_ctrl.sv | 165 ++++++++++++++++
 tb/tb_squash_game_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/squash_pkg.sv
// Shared types and sizing helpers for the squash game-flow controller.
// Pure declarations; no logic, latency or backpressure of its own.
package squash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_MISS   = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  localparam int BCD_W      = 4;
  localparam int BCD_DIGITS = 3;
  localparam int SCORE_W    = BCD_W * BCD_DIGITS;

  localparam logic [BCD_W-1:0]   BCD_NINE  = 4'd9;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 12'h999;

  // Counter width covering the longest phase; loaded with N-1, so $clog2(N) bits suffice.
  function automatic int frame_cnt_w(input int serve_f, input int miss_f, input int over_f);
    int m;
    m = serve_f;
    if (miss_f > m) m = miss_f;
    if (over_f > m) m = over_f;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/squash_bcd_counter.sv
// Three-digit BCD score counter: synchronous clear, +1 on inc, saturates at 999.
// Latency 1 cycle from inc/clr to value; no backpressure (one increment per asserted cycle).
module squash_bcd_counter
  import squash_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] value
);

  logic [BCD_W-1:0] ones, tens, hund;

  assign ones = value[BCD_W-1:0];
  assign tens = value[2*BCD_W-1:BCD_W];
  assign hund = value[3*BCD_W-1:2*BCD_W];

  // Carry ripples through all digits in one edge, so 099 -> 100 directly.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      value <= '0;
    end else if (inc && (value != SCORE_MAX)) begin
      if (ones != BCD_NINE) begin
        value[BCD_W-1:0] <= ones + 4'd1;
      end else begin
        value[BCD_W-1:0] <= '0;
        if (tens != BCD_NINE) begin
          value[2*BCD_W-1:BCD_W] <= tens + 4'd1;
        end else begin
          value[2*BCD_W-1:BCD_W]         <= '0;
          value[3*BCD_W-1:2*BCD_W] <= hund + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/squash_game_ctrl.sv
// Squash round sequencer: debounced start/pause, serve/play/miss/over phases, BCD score and lives.
// All outputs registered, 1 cycle after the causing input or frame_tick; no backpressure.
module squash_game_ctrl
  import squash_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90,
  parameter int OVER_FRAMES  = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        hit,
  input  logic        miss,
  input  logic        start_n,
  input  logic        pause_btn_n,
  output logic        pause_n,
  output logic        new_game_n,
  output logic [11:0] score_bcd,
  output logic [2:0]  lives,
  output logic        game_over,
  output logic [2:0]  state_out
);

  localparam int CW = frame_cnt_w(SERVE_FRAMES, MISS_FRAMES, OVER_FRAMES);

  localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] MISS_LOAD  = CW'(MISS_FRAMES - 1);
  localparam logic [CW-1:0] OVER_LOAD  = CW'(OVER_FRAMES - 1);
  localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

  logic       start_meta, start_sync, pause_meta, pause_sync;
  logic [1:0] start_sh, pause_sh;
  logic       hit_d, miss_d;
  logic       start_press, pause_press, hit_rise, miss_rise;

  state_t        state, state_nxt;
  logic [CW-1:0] frame_cnt, cnt_nxt;
  logic [2:0]    lives_nxt;
  logic          score_clr, score_inc;

  // Buttons are synchronised every cycle, then sampled once per frame for debounce.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_meta <= 1'b1;
      start_sync <= 1'b1;
      pause_meta <= 1'b1;
      pause_sync <= 1'b1;
      start_sh   <= 2'b11;
      pause_sh   <= 2'b11;
      hit_d      <= 1'b0;
      miss_d     <= 1'b0;
    end else begin
      start_meta <= start_n;
      start_sync <= start_meta;
      pause_meta <= pause_btn_n;
      pause_sync <= pause_meta;
      hit_d      <= hit;
      miss_d     <= miss;
      if (frame_tick) begin
        start_sh <= {start_sh[0], start_sync};
        pause_sh <= {pause_sh[0], pause_sync};
      end
    end
  end

  // Press = samples 1,0,0 on three consecutive frames (oldest first).
  assign start_press = frame_tick & start_sh[1] & ~start_sh[0] & ~start_sync;
  assign pause_press = frame_tick & pause_sh[1] & ~pause_sh[0] & ~pause_sync;
  assign hit_rise    = hit & ~hit_d;
  assign miss_rise   = miss & ~miss_d;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = frame_cnt;
    lives_nxt = lives;
    score_clr = 1'b0;
    score_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_press) begin
          state_nxt = ST_SERVE;
          cnt_nxt   = SERVE_LOAD;
          lives_nxt = LIVES_INIT;
          score_clr = 1'b1;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (frame_cnt == '0) state_nxt = ST_PLAY;
          else                 cnt_nxt   = frame_cnt - CW'(1);
        end
      end
      ST_PLAY: begin
        // A hit coinciding with a miss or pause still scores.
        score_inc = hit_rise;
        if (miss_rise) begin
          state_nxt = ST_MISS;
          cnt_nxt   = MISS_LOAD;
          lives_nxt = (lives != 3'd0) ? lives - 3'd1 : 3'd0;
        end else if (pause_press) begin
          state_nxt = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (pause_press) state_nxt = ST_PLAY;
      end
      ST_MISS: begin
        if (frame_tick) begin
          if (frame_cnt != '0) begin
            cnt_nxt = frame_cnt - CW'(1);
          end else if (lives == 3'd0) begin
            state_nxt = ST_OVER;
            cnt_nxt   = OVER_LOAD;
          end else begin
            state_nxt = ST_SERVE;
            cnt_nxt   = SERVE_LOAD;
          end
        end
      end
      ST_OVER: begin
        if (start_press) begin
          state_nxt = ST_SERVE;
          cnt_nxt   = SERVE_LOAD;
          lives_nxt = LIVES_INIT;
          score_clr = 1'b1;
        end else if (frame_tick) begin
          if (frame_cnt == '0) state_nxt = ST_IDLE;
          else                 cnt_nxt   = frame_cnt - CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      frame_cnt  <= '0;
      lives      <= LIVES_INIT;
      pause_n    <= 1'b0;
      new_game_n <= 1'b1;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_cnt  <= cnt_nxt;
      lives      <= lives_nxt;
      pause_n    <= (state_nxt == ST_PLAY);
      new_game_n <= (state_nxt != ST_SERVE);
      game_over  <= (state_nxt == ST_OVER);
    end
  end

  assign state_out = state;

  squash_bcd_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .value (score_bcd)
  );

endmodule

// File: tb/tb_squash_game_ctrl.sv
// Directed bench for squash_game_ctrl: game flow, score saturation, lives, pause, debounce and reset.
module tb_squash_game_ctrl;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SERVE  = 3'd1;
  localparam logic [2:0] S_PLAY   = 3'd2;
  localparam logic [2:0] S_PAUSED = 3'd3;
  localparam logic [2:0] S_MISS   = 3'd4;
  localparam logic [2:0] S_OVER   = 3'd5;

  logic        clk = 1'b0;
  logic        reset, frame_tick, hit, miss, start_n, pause_btn_n;
  logic        pause_n, new_game_n, game_over;
  logic [11:0] score_bcd;
  logic [2:0]  lives, state_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int frames   = 0;

  squash_game_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .hit         (hit),
    .miss        (miss),
    .start_n     (start_n),
    .pause_btn_n (pause_btn_n),
    .pause_n     (pause_n),
    .new_game_n  (new_game_n),
    .score_bcd   (score_bcd),
    .lives       (lives),
    .game_over   (game_over),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs change 1 time unit after the edge, frame_tick every 8th cycle.
  task automatic tick();
    if (frame_tick) frames++;
    @(posedge clk);
    #1;
    cyc++;
    frame_tick = (cyc % 8 == 0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_frames(input int n);
    int tgt;
    tgt = frames + n;
    while (frames < tgt) tick();
  endtask

  task automatic hit_pulse();
    hit = 1'b1;
    tick();
    hit = 1'b0;
    tick();
  endtask

  task automatic miss_pulse();
    miss = 1'b1;
    tick();
    miss = 1'b0;
  endtask

  task automatic press_pause();
    wait_frames(1);
    pause_btn_n = 1'b0;
    wait_frames(2);
    pause_btn_n = 1'b1;
    wait_frames(2);
  endtask

  // Start press lands on the 2nd low frame sample; SERVE then lasts 60 frames.
  task automatic start_game();
    wait_frames(1);
    start_n = 1'b0;
    wait_frames(2);
    start_n = 1'b1;
    wait_frames(60);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; hit = 1'b0; miss = 1'b0;
    start_n = 1'b1; pause_btn_n = 1'b1;
    cycles(3);
    chk("rst_state",  32'(state_out),  S_IDLE);
    chk("rst_pause",  32'(pause_n),    0);
    chk("rst_newg",   32'(new_game_n), 1);
    chk("rst_score",  32'(score_bcd),  'h000);
    chk("rst_lives",  32'(lives),      3);
    chk("rst_over",   32'(game_over),  0);
    reset = 1'b0;

    // Game 1: exact serve length
    wait_frames(1);
    start_n = 1'b0;
    wait_frames(2);
    chk("serve_state", 32'(state_out),  S_SERVE);
    chk("serve_newg",  32'(new_game_n), 0);
    chk("serve_pause", 32'(pause_n),    0);
    chk("serve_lives", 32'(lives),      3);
    chk("serve_score", 32'(score_bcd),  'h000);
    wait_frames(1);
    start_n = 1'b1;
    wait_frames(58);
    chk("serve_last",  32'(state_out),  S_SERVE);
    wait_frames(1);
    chk("play_state",  32'(state_out),  S_PLAY);
    chk("play_pause",  32'(pause_n),    1);
    chk("play_newg",   32'(new_game_n), 1);

    hit_pulse();
    chk("hit_first", 32'(score_bcd), 'h001);
    for (int i = 0; i < 4; i++) hit_pulse();
    chk("hit_five", 32'(score_bcd), 'h005);
    hit = 1'b1;
    cycles(100);
    hit = 1'b0;
    tick();
    chk("hit_held", 32'(score_bcd), 'h006);

    press_pause();
    chk("paused_state", 32'(state_out), S_PAUSED);
    chk("paused_pause", 32'(pause_n),   0);
    hit_pulse();
    chk("paused_hit",   32'(score_bcd), 'h006);
    press_pause();
    chk("resume_state", 32'(state_out), S_PLAY);
    chk("resume_pause", 32'(pause_n),   1);
    wait_frames(1);
    pause_btn_n = 1'b0;
    wait_frames(1);
    pause_btn_n = 1'b1;
    wait_frames(3);
    chk("glitch_state", 32'(state_out), S_PLAY);

    for (int i = 0; i < 93; i++) hit_pulse();
    chk("score_099", 32'(score_bcd), 'h099);
    hit_pulse();
    chk("score_100", 32'(score_bcd), 'h100);
    for (int i = 0; i < 899; i++) hit_pulse();
    chk("score_999", 32'(score_bcd), 'h999);
    hit_pulse();
    chk("score_sat", 32'(score_bcd), 'h999);

    for (int k = 0; k < 3; k++) begin
      miss_pulse();
      chk("miss_state", 32'(state_out), S_MISS);
      chk("miss_lives", 32'(lives),     2 - k);
      chk("miss_pause", 32'(pause_n),   0);
      if (k < 2) begin
        wait_frames(90);
        chk("miss_serve", 32'(state_out), S_SERVE);
        chk("miss_keep",  32'(score_bcd), 'h999);
        wait_frames(60);
        chk("miss_play",  32'(state_out), S_PLAY);
      end
    end
    wait_frames(89);
    chk("miss_last",   32'(state_out), S_MISS);
    wait_frames(1);
    chk("over_state",  32'(state_out), S_OVER);
    chk("over_flag",   32'(game_over), 1);
    chk("over_lives",  32'(lives),     0);
    wait_frames(239);
    chk("over_last",   32'(state_out), S_OVER);
    wait_frames(1);
    chk("idle_state",  32'(state_out), S_IDLE);
    chk("idle_flag",   32'(game_over), 0);
    chk("idle_score",  32'(score_bcd), 'h999);

    // Game 2: simultaneous hit+miss, then reset mid-MISS
    start_game();
    chk("g2_state", 32'(state_out), S_PLAY);
    chk("g2_score", 32'(score_bcd), 'h000);
    chk("g2_lives", 32'(lives),     3);
    for (int i = 0; i < 41; i++) hit_pulse();
    hit = 1'b1;
    miss = 1'b1;
    tick();
    hit = 1'b0;
    miss = 1'b0;
    chk("both_score", 32'(score_bcd), 'h042);
    chk("both_lives", 32'(lives),     2);
    chk("both_state", 32'(state_out), S_MISS);
    wait_frames(10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_state", 32'(state_out),  S_IDLE);
    chk("mrst_score", 32'(score_bcd),  'h000);
    chk("mrst_lives", 32'(lives),      3);
    chk("mrst_pause", 32'(pause_n),    0);
    chk("mrst_newg",  32'(new_game_n), 1);

    // Game 3: restart directly from OVER
    start_game();
    for (int k = 0; k < 3; k++) begin
      miss_pulse();
      wait_frames((k < 2) ? 150 : 90);
    end
    chk("g3_over", 32'(state_out), S_OVER);
    wait_frames(5);
    start_n = 1'b0;
    wait_frames(2);
    start_n = 1'b1;
    chk("restart_state", 32'(state_out), S_SERVE);
    chk("restart_score", 32'(score_bcd), 'h000);
    chk("restart_lives", 32'(lives),     3);
    chk("restart_over",  32'(game_over), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
